demux_frame_sequencer: RTL
==========================

DEMUX_FRAME_SEQUENCER -- requirements
Module: demux_frame_sequencer

Interface
REQ-001 SHALL have parameter PAYLOAD_LEN, default 4: payload bits per frame, legal range 1..15.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-004 SHALL have port start, input, 1 bit: frame-start strobe, sampled only in IDLE.
REQ-005 SHALL have port din, input, 1 bit: serial frame bit.
REQ-006 SHALL have port din_valid, input, 1 bit: din qualifier; a bit is accepted on a rising edge with din_valid=1 in ADDR0, ADDR1, DATA or PARITY.
REQ-007 SHALL have ports s0 and s1, outputs, 1 bit each: channel select lines feeding the downstream 1:4 demux.
REQ-008 SHALL have port dout, output, 1 bit: data bit feeding the demux data input.
REQ-009 SHALL have port dout_valid, output, 1 bit: dout qualifier.
REQ-010 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-011 SHALL have port frame_done, output, 1 bit: one-cycle end-of-frame pulse.
REQ-012 SHALL have port parity_err, output, 1 bit: one-cycle parity-failure pulse.

Function
REQ-013 SHALL implement FSM states IDLE, ADDR0, ADDR1, DATA, PARITY (macro-dependent) and DONE.
REQ-014 IDLE: start=1 SHALL move the FSM to ADDR0; din/din_valid in that same cycle SHALL be ignored.
REQ-015 ADDR0: an accepted bit SHALL be stored in shadow select bit a0, then ADDR1.
REQ-016 ADDR1: an accepted bit SHALL be stored in shadow a1, then DATA; s0<=a0 and s1<=din SHALL update together on this edge, never separately.
REQ-017 s0/s1 SHALL hold their value from the end of ADDR1 until the next frame's ADDR1 edge.
REQ-018 DATA: each accepted bit SHALL set dout<=din and dout_valid<=1 on the same edge (1-cycle latency); otherwise dout_valid<=0 and dout<=0.
REQ-019 A 4-bit counter SHALL count accepted payload bits; on acceptance of bit PAYLOAD_LEN the FSM SHALL leave DATA (to PARITY or DONE).
REQ-020 DONE SHALL last exactly one cycle with frame_done=1, then IDLE.
REQ-021 start outside IDLE SHALL be ignored; cycles with din_valid=0 SHALL stall the FSM with no output change except dout_valid=0.
REQ-022 s0, s1, dout, dout_valid and frame_done SHALL all be registered outputs.

Reset
REQ-023 rst_n=0 SHALL force IDLE and clear s0, s1, dout, dout_valid, busy, frame_done, parity_err, shadow bits and counter to 0 immediately, including mid-frame.
REQ-024 After rst_n deasserts, the block SHALL accept start on the first rising edge.

Configuration
REQ-025 Macro DEMUX_FRAME_PARITY_EN defined: after DATA the FSM SHALL enter PARITY, accept one bit, and require even parity over a0, a1, all payload bits and the parity bit; on mismatch parity_err SHALL pulse during the DONE cycle.
REQ-026 Macro undefined: PARITY state SHALL not exist, DATA goes directly to DONE, parity_err SHALL be constant 0.
REQ-027 s0/s1/dout behaviour SHALL be identical in both builds; parity failure SHALL not suppress already-issued dout_valid pulses.

Verification
REQ-028 Reset, start pulse, din_valid=1 each cycle, bits 1,0 then 1,0,1,1 -> s0=1,s1=0 from the DATA entry edge; dout_valid 4 consecutive cycles with dout 1,0,1,1; frame_done one cycle later; busy low afterwards.
REQ-029 Same frame with din_valid=0 gaps of 2 cycles between every bit -> identical dout sequence, dout_valid only after accepted bits, no select change during gaps.
REQ-030 Two back-to-back frames addressed 0,0 then 1,1 -> s0/s1 stay 0,0 through the second frame's ADDR0/ADDR1 and change to 1,1 in one edge.
REQ-031 start held high throughout DATA -> no restart; start and din_valid=1 together in IDLE -> din not used as a0.
REQ-032 rst_n pulled low after second payload bit -> all outputs 0 asynchronously; next start begins a clean frame.
REQ-033 With DEMUX_FRAME_PARITY_EN: address 1,0, payload 1,0,1,1, parity bit 0 -> parity_err=0; parity bit 1 -> parity_err=1 coincident with frame_done; without the macro parity_err stays 0.

Source files
------------

// File: rtl/demux_frame_sequencer.sv
// Serial frame sequencer: two address bits set the demux selects, then PAYLOAD_LEN
// data bits are forwarded on dout. Optional even-parity check via DEMUX_FRAME_PARITY_EN.
module demux_frame_sequencer #(
  parameter int PAYLOAD_LEN = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       din,
  input  logic       din_valid,
  output logic       s0,
  output logic       s1,
  output logic       dout,
  output logic       dout_valid,
  output logic       busy,
  output logic       frame_done,
  output logic       parity_err,
  output logic [2:0] fsm_state
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ADDR0  = 3'd1,
    ADDR1  = 3'd2,
    DATA   = 3'd3,
`ifdef DEMUX_FRAME_PARITY_EN
    PARITY = 3'd4,
`endif
    DONE   = 3'd5
  } state_t;

  localparam logic [3:0] LAST_IDX = 4'(PAYLOAD_LEN - 1);

  state_t     state, state_d;
  logic       a0_q, a0_d;
  logic [3:0] cnt_q, cnt_d;
  logic       s0_d, s1_d, dout_d, dv_d, fd_d;

`ifdef DEMUX_FRAME_PARITY_EN
  // a1 is only needed for the parity sum; otherwise s1 already carries it.
  logic a1_q, a1_d;
  logic ppar_q, ppar_d;
  logic perr_q, perr_d;
`endif

  // Handshake: a bit transfers on a rising edge where din_valid=1 and the FSM is in
  // ADDR0/ADDR1/DATA/PARITY; there is no back-pressure, so din_valid=0 simply stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    a0_d    = a0_q;
    cnt_d   = cnt_q;
    s0_d    = s0;
    s1_d    = s1;
    dout_d  = 1'b0;
    dv_d    = 1'b0;
    fd_d    = 1'b0;
`ifdef DEMUX_FRAME_PARITY_EN
    a1_d    = a1_q;
    ppar_d  = ppar_q;
    perr_d  = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (start) begin
          state_d = ADDR0;
          cnt_d   = 4'd0;
`ifdef DEMUX_FRAME_PARITY_EN
          ppar_d  = 1'b0;
`endif
        end
      end
      ADDR0: begin
        if (din_valid) begin
          a0_d    = din;
          state_d = ADDR1;
        end
      end
      ADDR1: begin
        // Both selects switch on one edge so the demux never sees a mixed address.
        if (din_valid) begin
          s0_d    = a0_q;
          s1_d    = din;
          state_d = DATA;
`ifdef DEMUX_FRAME_PARITY_EN
          a1_d    = din;
`endif
        end
      end
      DATA: begin
        if (din_valid) begin
          dout_d = din;
          dv_d   = 1'b1;
          cnt_d  = cnt_q + 4'd1;
`ifdef DEMUX_FRAME_PARITY_EN
          ppar_d = ppar_q ^ din;
          if (cnt_q == LAST_IDX) state_d = PARITY;
`else
          if (cnt_q == LAST_IDX) begin
            state_d = DONE;
            fd_d    = 1'b1;
          end
`endif
        end
      end
`ifdef DEMUX_FRAME_PARITY_EN
      PARITY: begin
        if (din_valid) begin
          state_d = DONE;
          fd_d    = 1'b1;
          perr_d  = a0_q ^ a1_q ^ ppar_q ^ din;
        end
      end
`endif
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a0_q       <= 1'b0;
      cnt_q      <= 4'd0;
      s0         <= 1'b0;
      s1         <= 1'b0;
      dout       <= 1'b0;
      dout_valid <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      a0_q       <= a0_d;
      cnt_q      <= cnt_d;
      s0         <= s0_d;
      s1         <= s1_d;
      dout       <= dout_d;
      dout_valid <= dv_d;
      frame_done <= fd_d;
    end
  end

`ifdef DEMUX_FRAME_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a1_q   <= 1'b0;
      ppar_q <= 1'b0;
      perr_q <= 1'b0;
    end else begin
      a1_q   <= a1_d;
      ppar_q <= ppar_d;
      perr_q <= perr_d;
    end
  end
  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif

  assign busy      = (state != IDLE);
  assign fsm_state = state;

endmodule
